monobit_bit_source: RTL and testbench

- Bit-stream producer feeding the monobit (frequency) test engine.
- Serializes host-loaded bytes, or generates pseudo-random bits from an internal 16-bit Galois LFSR, into a 1-bit valid/ready stream.
- Frames the stream into fixed-length test blocks with start/last markers. Sits between the pin-level byte interface and the monobit counter.

---
 rtl/monobit_pkg.sv | 23 ++
 rtl/monobit_bit_source_if.sv | 24 ++
 rtl/monobit_lfsr16.sv | 24 ++
 rtl/monobit_bit_source.sv | 109 ++++++++++
 tb/tb_monobit_bit_source.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit bit source and the LFSR it reuses
// with the checker's self-test.
package monobit_pkg;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    typedef enum logic [0:0] {
        SRC_BYTE = 1'b0,
        SRC_LFSR = 1'b1
    } src_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LFSR
    } state_e;

    function automatic int BLOCK_CNT_W(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/monobit_bit_source_if.sv
// Byte-in / bit-out stream bundle; master is the bit source, slave is its environment.
interface monobit_bit_source_if;
    logic        ena;
    logic        mode;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        block_first;
    logic        block_last;
    logic [15:0] blocks_done;

    modport master (
        input  ena, mode, in_data, in_valid, bit_ready,
        output in_ready, bit_out, bit_valid, block_first, block_last, blocks_done
    );

    modport slave (
        output ena, mode, in_data, in_valid, bit_ready,
        input  in_ready, bit_out, bit_valid, block_first, block_last, blocks_done
    );
endinterface

// File: rtl/monobit_lfsr16.sv
// 16-bit Galois LFSR; state[0] is the output bit. Never reaches zero from a nonzero seed.
module monobit_lfsr16
    import monobit_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SEED;
        else if (load)
            state <= seed;
        else if (adv)
            state <= (state >> 1) ^ (state[0] ? LFSR_POLY : 16'h0000);
    end

endmodule

// File: rtl/monobit_bit_source.sv
// Serializes host bytes or LFSR bits into a framed 1-bit valid/ready stream
// for the monobit counter.
module monobit_bit_source
    import monobit_pkg::*;
#(
    parameter int          BLOCK_LEN = 128,
    parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    monobit_bit_source_if.master sio
);

    localparam int             CW   = BLOCK_CNT_W(BLOCK_LEN);
    localparam logic [CW-1:0]  LAST = CW'(BLOCK_LEN - 1);

    state_e        state;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [15:0]   done_q;
    logic [15:0]   lfsr_q;

    logic xfer, accept, blk_end, blk_zero, want_lfsr, byte_bit;

    assign want_lfsr = (sio.mode == SRC_LFSR);
    assign blk_end   = (cnt == LAST);
    assign blk_zero  = (cnt == '0);
    assign byte_bit  = MSB_FIRST ? shreg[3'd7 - idx] : shreg[idx];

    assign sio.bit_valid   = sio.ena && !rst && (state != ST_IDLE);
    assign sio.bit_out     = (state == ST_LFSR) ? lfsr_q[0] : byte_bit;
    assign sio.block_first = sio.bit_valid && blk_zero;
    assign sio.block_last  = sio.bit_valid && blk_end;
    assign sio.blocks_done = done_q;

    assign xfer   = sio.bit_valid && sio.bit_ready;
    assign accept = sio.in_valid && sio.in_ready;

    // A byte is refused when the block boundary is about to hand over to the LFSR,
    // otherwise it would be loaded and then dropped.
    always_comb begin
        sio.in_ready = 1'b0;
        if (sio.ena && !rst) begin
            case (state)
                ST_IDLE:  sio.in_ready = !(blk_zero && want_lfsr);
                ST_SHIFT: sio.in_ready = sio.bit_ready && (idx == 3'd7) &&
                                         !(blk_end && want_lfsr);
                default:  sio.in_ready = 1'b0;
            endcase
        end
    end

    monobit_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b0),
        .seed  (LFSR_SEED),
        .adv   (xfer && (state == ST_LFSR)),
        .state (lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            idx    <= '0;
            cnt    <= '0;
            done_q <= '0;
        end else begin
            if (xfer) begin
                cnt <= blk_end ? '0 : cnt + CW'(1);
                if (blk_end)
                    done_q <= done_q + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (sio.ena && blk_zero && want_lfsr) begin
                        state <= ST_LFSR;
                    end else if (accept) begin
                        shreg <= sio.in_data;
                        idx   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (xfer) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            if (accept)
                                shreg <= sio.in_data;
                            else if (blk_end && want_lfsr)
                                state <= ST_LFSR;
                            else
                                state <= ST_IDLE;
                        end
                    end
                end
                ST_LFSR: begin
                    if (xfer && blk_end && !want_lfsr)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monobit_bit_source.sv
// Directed bench for monobit_bit_source with BLOCK_LEN=16, MSB-first bytes.
module tb_monobit_bit_source;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    monobit_bit_source_if sio();

    monobit_bit_source #(
        .BLOCK_LEN (16),
        .LFSR_SEED (16'hACE1),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sio (sio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] pat;

    initial begin
        sio.ena       = 1'b1;
        sio.mode      = 1'b0;
        sio.in_data   = 8'h00;
        sio.in_valid  = 1'b0;
        sio.bit_ready = 1'b1;

        // reset state
        step();
        step();
        chk("rst_bit_valid", 16'(sio.bit_valid), 16'd0);
        chk("rst_in_ready", 16'(sio.in_ready), 16'd0);
        chk("rst_blocks_done", sio.blocks_done, 16'd0);
        chk("rst_lfsr", dut.u_lfsr.state, 16'hACE1);
        rst = 1'b0;
        #1;

        // byte order A5
        sio.in_data  = 8'hA5;
        sio.in_valid = 1'b1;
        #1;
        chk("a5_in_ready_idle", 16'(sio.in_ready), 16'd1);
        chk("a5_valid_before", 16'(sio.bit_valid), 16'd0);
        step();
        sio.in_valid = 1'b0;
        #1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit_valid", 16'(sio.bit_valid), 16'd1);
            chk("a5_bit_out", 16'(sio.bit_out), 16'(pat[7-i]));
            step();
        end
        chk("a5_valid_drop", 16'(sio.bit_valid), 16'd0);

        // back-to-back FF,00 forming one 16-bit block; mode flips at bit 5
        do_reset();
        sio.in_data  = 8'hFF;
        sio.in_valid = 1'b1;
        step();
        sio.in_data = 8'h00;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) sio.mode = 1'b1;
            if (i == 8) sio.in_valid = 1'b0;
            #1;
            chk("b2b_valid", 16'(sio.bit_valid), 16'd1);
            chk("b2b_bit", 16'(sio.bit_out), 16'(i < 8));
            chk("b2b_in_ready", 16'(sio.in_ready), 16'(i == 7));
            chk("b2b_first", 16'(sio.block_first), 16'(i == 0));
            chk("b2b_last", 16'(sio.block_last), 16'(i == 15));
            step();
        end
        chk("frame_blocks_done", sio.blocks_done, 16'd1);

        // LFSR takes over at bit 17
        chk("lfsr_first_flag", 16'(sio.block_first), 16'd1);
        chk("lfsr_valid", 16'(sio.bit_valid), 16'd1);
        chk("lfsr_seed", dut.u_lfsr.state, 16'hACE1);
        chk("lfsr_bit0", 16'(sio.bit_out), 16'd1);
        chk("lfsr_in_ready", 16'(sio.in_ready), 16'd0);
        step();
        chk("lfsr_state1", dut.u_lfsr.state, 16'hE270);
        chk("lfsr_bit1", 16'(sio.bit_out), 16'd0);
        chk("lfsr_first_clr", 16'(sio.block_first), 16'd0);

        // ena low freezes everything
        sio.ena = 1'b0;
        #1;
        chk("ena_valid", 16'(sio.bit_valid), 16'd0);
        chk("ena_in_ready", 16'(sio.in_ready), 16'd0);
        step();
        step();
        chk("ena_lfsr_hold", dut.u_lfsr.state, 16'hE270);
        sio.ena = 1'b1;
        #1;
        chk("ena_resume_bit", 16'(sio.bit_out), 16'd0);
        chk("ena_resume_valid", 16'(sio.bit_valid), 16'd1);

        // backpressure on the 3rd bit of 3C
        sio.mode = 1'b0;
        do_reset();
        sio.in_data  = 8'h3C;
        sio.in_valid = 1'b1;
        step();
        sio.in_valid = 1'b0;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                sio.bit_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("bp_hold_valid", 16'(sio.bit_valid), 16'd1);
                    chk("bp_hold_bit", 16'(sio.bit_out), 16'd1);
                    chk("bp_hold_first", 16'(sio.block_first), 16'd0);
                    step();
                end
                sio.bit_ready = 1'b1;
            end
            #1;
            chk("bp_bit", 16'(sio.bit_out), 16'(pat[7-i]));
            step();
        end
        chk("bp_done_valid", 16'(sio.bit_valid), 16'd0);

        // reset at the 10th bit of a block
        do_reset();
        sio.in_data  = 8'hFF;
        sio.in_valid = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("mid_valid_before", 16'(sio.bit_valid), 16'd1);
        chk("mid_first_before", 16'(sio.block_first), 16'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(sio.bit_valid), 16'd0);
        chk("mid_rst_in_ready", 16'(sio.in_ready), 16'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_blocks_done", sio.blocks_done, 16'd0);
        step();
        chk("mid_after_first", 16'(sio.block_first), 16'd1);
        chk("mid_after_valid", 16'(sio.bit_valid), 16'd1);
        sio.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
